// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter for icache refill and dcache refill/writeback bursts.
module mem_arbiter #(
  parameter int unsigned BEATS    = 4,
  parameter int unsigned OFF_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_req_valid,
  input  logic [31:0] ic_req_addr,
  output logic        ic_req_ready,
  output logic        ic_resp_valid,
  output logic [31:0] ic_resp_data,
  output logic        ic_done,
  input  logic        dc_req_valid,
  input  logic [31:0] dc_req_addr,
  input  logic        dc_req_rw,
  output logic        dc_req_ready,
  input  logic [31:0] dc_wdata,
  output logic        dc_wdata_ready,
  output logic        dc_resp_valid,
  output logic [31:0] dc_resp_data,
  output logic        dc_done,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_rw,
  output logic        mem_wdata_valid,
  output logic [31:0] mem_wdata,
  input  logic        mem_wdata_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        busy
);

  localparam int unsigned  CW        = $clog2(BEATS);
  localparam logic [31:0]  ADDR_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  owner_t        last_q, last_d;
  owner_t        owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic          ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d;
  logic [31:0]   ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;

  // State and datapath registers; reset discards any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      last_q  <= OWN_I;
      owner_q <= OWN_I;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      ic_rv_q <= 1'b0;
      dc_rv_q <= 1'b0;
      ic_rd_q <= '0;
      dc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      ic_rv_q <= ic_rv_d;
      dc_rv_q <= dc_rv_d;
      ic_rd_q <= ic_rd_d;
      dc_rd_q <= dc_rd_d;
    end
  end

  // Next-state, grant and memory-port control.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    last_d          = last_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    rw_d            = rw_q;
    ic_rv_d         = 1'b0;
    dc_rv_d         = 1'b0;
    ic_rd_d         = ic_rd_q;
    dc_rd_d         = dc_rd_q;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    mem_req_rw      = 1'b0;
    mem_wdata_valid = 1'b0;
    mem_wdata       = '0;
    dc_wdata_ready  = 1'b0;
    ic_done         = 1'b0;
    dc_done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!reset && (ic_req_valid || dc_req_valid)) begin
          // Tie goes to whichever side did not win last time.
          if (dc_req_valid && (!ic_req_valid || last_q == OWN_I)) begin
            dc_req_ready = 1'b1;
            owner_d      = OWN_D;
            last_d       = OWN_D;
            addr_d       = dc_req_addr & ADDR_MASK;
            rw_d         = dc_req_rw;
          end else begin
            ic_req_ready = 1'b1;
            owner_d      = OWN_I;
            last_d       = OWN_I;
            addr_d       = ic_req_addr & ADDR_MASK;
            rw_d         = 1'b0;
          end
          beat_d  = '0;
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_rw    = rw_q;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = rw_q ? S_WDATA : S_RDATA;
        end
      end

      S_WDATA: begin
        mem_wdata_valid = 1'b1;
        mem_wdata       = dc_wdata;
        dc_wdata_ready  = mem_wdata_ready;
        if (mem_wdata_ready) begin
          beat_d = beat_q + CW'(1);
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end
      end

      S_RDATA: begin
        if (mem_resp_valid) begin
          if (owner_q == OWN_D) begin
            dc_rv_d = 1'b1;
            dc_rd_d = mem_resp_data;
          end else begin
            ic_rv_d = 1'b1;
            ic_rd_d = mem_resp_data;
          end
          beat_d = beat_q + CW'(1);
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end
      end

      S_DONE: begin
        ic_done = (owner_q == OWN_I);
        dc_done = (owner_q == OWN_D);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ic_resp_valid = ic_rv_q;
  assign ic_resp_data  = ic_rd_q;
  assign dc_resp_valid = dc_rv_q;
  assign dc_resp_data  = dc_rd_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions vs a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned BEATS    = 4;
  localparam int unsigned OFF_BITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req_valid, ic_req_ready, ic_resp_valid, ic_done;
  logic [31:0] ic_req_addr, ic_resp_data;
  logic        dc_req_valid, dc_req_rw, dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_done;
  logic [31:0] dc_req_addr, dc_wdata, dc_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_rw, mem_wdata_valid, mem_wdata_ready;
  logic        mem_resp_valid, busy;
  logic [31:0] mem_req_addr, mem_wdata, mem_resp_data;

  int errors = 0;
  int checks = 0;

  // Model state: pending requests per side and the last granted side (1 = D).
  bit          ic_p, dc_p, dc_rw, last_d;
  logic [31:0] ic_a, dc_a;

  always #5 clk = ~clk;

  mem_arbiter #(.BEATS(BEATS), .OFF_BITS(OFF_BITS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_done(ic_done),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
    .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wdata_ready(dc_wdata_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_done(dc_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata),
    .mem_wdata_ready(mem_wdata_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic icr, input logic dcr, input logic mrv,
                          input logic wv, input logic wr, input logic icrv, input logic dcrv,
                          input logic icd, input logic dcd, input logic bsy);
    chk1($sformatf("%s.ic_req_ready", tag), ic_req_ready, icr);
    chk1($sformatf("%s.dc_req_ready", tag), dc_req_ready, dcr);
    chk1($sformatf("%s.mem_req_valid", tag), mem_req_valid, mrv);
    chk1($sformatf("%s.mem_wdata_valid", tag), mem_wdata_valid, wv);
    chk1($sformatf("%s.dc_wdata_ready", tag), dc_wdata_ready, wr);
    chk1($sformatf("%s.ic_resp_valid", tag), ic_resp_valid, icrv);
    chk1($sformatf("%s.dc_resp_valid", tag), dc_resp_valid, dcrv);
    chk1($sformatf("%s.ic_done", tag), ic_done, icd);
    chk1($sformatf("%s.dc_done", tag), dc_done, dcd);
    chk1($sformatf("%s.busy", tag), busy, bsy);
  endtask

  // One IDLE cycle: present pending requests, predict the round-robin grant.
  task automatic idle_cycle(input bit allow_new, output bit g, output bit gd,
                            output logic [31:0] ga, output bit grw);
    if (allow_new && !ic_p && $urandom_range(0, 1) == 1) begin
      ic_p = 1'b1; ic_a = $urandom;
    end
    if (allow_new && !dc_p && $urandom_range(0, 1) == 1) begin
      dc_p = 1'b1; dc_a = $urandom; dc_rw = 1'($urandom_range(0, 1));
    end
    ic_req_valid = ic_p; ic_req_addr = ic_a;
    dc_req_valid = dc_p; dc_req_addr = dc_a; dc_req_rw = dc_rw;
    mem_req_ready   = 1'b0;
    mem_resp_valid  = 1'($urandom_range(0, 1));
    mem_resp_data   = $urandom;
    mem_wdata_ready = 1'($urandom_range(0, 1));
    g   = ic_p || dc_p;
    gd  = dc_p && (!ic_p || !last_d);
    ga  = gd ? dc_a : ic_a;
    grw = gd ? dc_rw : 1'b0;
    #3;
    chk_ctrl("idle", g && !gd, g && gd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    mem_resp_valid  = 1'b0;
    mem_wdata_ready = 1'b0;
    if (g) begin
      last_d = gd;
      if (gd) dc_p = 1'b0;
      else    ic_p = 1'b0;
    end
    ic_req_valid = ic_p;
    dc_req_valid = dc_p;
  endtask

  // Command, data and done phases of a granted transaction.
  task automatic run_txn(input bit gd, input logic [31:0] ga, input bit grw, input int stall,
                         input bit dense, input logic [31:0] dbase);
    logic [31:0] ea, pd, d;
    int          n, beats;
    bit          rdy, pend, v;
    ea = ga - (ga % (BEATS * 4));
    n  = 0;
    do begin
      rdy = (stall >= 0) ? (n == stall) : (n >= 8 || $urandom_range(0, 2) == 0);
      mem_req_ready = rdy;
      #3;
      chk_ctrl("cmd", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk32("cmd.addr", mem_req_addr, ea);
      chk1("cmd.rw", mem_req_rw, grw);
      tick();
      n++;
    end while (!rdy);
    mem_req_ready = 1'b0;
    beats = 0;
    pend  = 1'b0;
    pd    = '0;
    if (grw) begin
      while (beats < BEATS) begin
        mem_wdata_ready = dense | 1'($urandom_range(0, 1));
        dc_wdata        = $urandom;
        #3;
        chk_ctrl("wr", 1'b0, 1'b0, 1'b0, 1'b1, mem_wdata_ready, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk32("wr.data", mem_wdata, dc_wdata);
        if (mem_wdata_ready) beats++;
        tick();
      end
      mem_wdata_ready = 1'b0;
    end else begin
      while (beats < BEATS) begin
        v = dense | 1'($urandom_range(0, 1));
        d = dense ? dbase + 32'(beats) : $urandom;
        mem_resp_valid = v;
        mem_resp_data  = d;
        #3;
        chk_ctrl("rd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !gd && pend, gd && pend, 1'b0, 1'b0, 1'b1);
        if (pend) chk32("rd.data", gd ? dc_resp_data : ic_resp_data, pd);
        tick();
        pend = v;
        pd   = d;
        if (v) beats++;
      end
      mem_resp_valid = 1'b0;
    end
    #3;
    chk_ctrl("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !gd && pend, gd && pend, !gd, gd, 1'b1);
    if (pend) chk32("done.data", gd ? dc_resp_data : ic_resp_data, pd);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          g, gd, grw;
    logic [31:0] ga;
    int          guard;

    reset = 1'b1;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_rw = 1'b0; dc_wdata = '0;
    mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    ic_p = 1'b0; dc_p = 1'b0; dc_rw = 1'b0; last_d = 1'b0; ic_a = '0; dc_a = '0;
    tick();
    tick();
    #3;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk32("reset.ic_resp_data", ic_resp_data, 32'h0);
    chk32("reset.dc_resp_data", dc_resp_data, 32'h0);
    chk32("reset.mem_req_addr", mem_req_addr, 32'h0);
    chk32("reset.mem_wdata", mem_wdata, 32'h0);
    chk1("reset.mem_req_rw", mem_req_rw, 1'b0);
    reset = 1'b0;
    tick();

    // Tie from reset: dcache write wins, then the waiting icache read with a 5-cycle command stall.
    ic_p = 1'b1; ic_a = 32'h0000_1238;
    dc_p = 1'b1; dc_a = 32'h0000_0400; dc_rw = 1'b1;
    idle_cycle(1'b0, g, gd, ga, grw);
    run_txn(gd, ga, grw, -1, 1'b0, 32'h0);
    idle_cycle(1'b0, g, gd, ga, grw);
    run_txn(gd, ga, grw, 5, 1'b1, 32'h0000_00A0);

    // Second tie: dcache again, then icache granted right after DONE.
    ic_p = 1'b1; ic_a = $urandom;
    dc_p = 1'b1; dc_a = $urandom; dc_rw = 1'b0;
    idle_cycle(1'b0, g, gd, ga, grw);
    run_txn(gd, ga, grw, 0, 1'b1, 32'h0000_0B00);
    idle_cycle(1'b0, g, gd, ga, grw);
    run_txn(gd, ga, grw, -1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      guard = 0;
      do begin
        idle_cycle(1'b1, g, gd, ga, grw);
        guard++;
      end while (!g && guard < 50);
      if (g) run_txn(gd, ga, grw, -1, 1'b0, 32'h0);
    end
    guard = 0;
    while ((ic_p || dc_p) && guard < 4) begin
      idle_cycle(1'b0, g, gd, ga, grw);
      run_txn(gd, ga, grw, -1, 1'b0, 32'h0);
      guard++;
    end

    // Reset in the middle of an icache read after two beats.
    ic_p = 1'b1; ic_a = 32'h0000_2004; dc_p = 1'b0;
    idle_cycle(1'b0, g, gd, ga, grw);
    mem_req_ready = 1'b1;
    #3;
    chk1("mr.cmd_valid", mem_req_valid, 1'b1);
    chk32("mr.cmd_addr", mem_req_addr, 32'h0000_2000);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_00B0;
    tick();
    mem_resp_data = 32'h0000_00B1;
    #3;
    chk1("mr.beat0_valid", ic_resp_valid, 1'b1);
    chk32("mr.beat0_data", ic_resp_data, 32'h0000_00B0);
    tick();
    reset = 1'b1;
    mem_resp_data = 32'h0000_00B2;
    #3;
    chk1("mr.beat1_valid", ic_resp_valid, 1'b1);
    chk32("mr.beat1_data", ic_resp_data, 32'h0000_00B1);
    tick();
    reset = 1'b0;
    last_d = 1'b0;
    mem_resp_data = 32'h0000_00B3;
    #3;
    chk_ctrl("mr.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk32("mr.abort.ic_resp_data", ic_resp_data, 32'h0);
    tick();
    mem_resp_valid = 1'b0;
    #3;
    chk_ctrl("mr.late", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // After the abort the arbiter grants normally again.
    ic_p = 1'b1; ic_a = $urandom; dc_p = 1'b1; dc_a = $urandom; dc_rw = 1'b1;
    idle_cycle(1'b0, g, gd, ga, grw);
    run_txn(gd, ga, grw, -1, 1'b0, 32'h0);
    idle_cycle(1'b0, g, gd, ga, grw);
    run_txn(gd, ga, grw, -1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared main-memory port between the instruction-cache refill path (read-only) and the data-cache refill/writeback path (read or write).
- Sits between the cache controllers and the external memory interface, below the 3-stage pipeline's icache/dcache.
- Each transaction is one line-aligned burst of BEATS 32-bit words.
- Ties are resolved round-robin, so neither cache starves.

Parameters:
BEATS, 4, words per cache-line burst; power of two, 2..16
OFF_BITS, 4, low address bits forced to zero on the memory port; must equal log2(BEATS)+2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ic_req_valid  input  1  icache requests a line read
ic_req_addr  input  32  icache request address
ic_req_ready  output  1  icache request accepted this cycle
ic_resp_valid  output  1  one read beat for icache
ic_resp_data  output  32  icache read beat data
ic_done  output  1  one-cycle pulse: icache transaction complete
dc_req_valid  input  1  dcache requests a transaction
dc_req_addr  input  32  dcache request address
dc_req_rw  input  1  1 = line write, 0 = line read
dc_req_ready  output  1  dcache request accepted this cycle
dc_wdata  input  32  current write beat from dcache
dc_wdata_ready  output  1  dcache write beat consumed this cycle
dc_resp_valid  output  1  one read beat for dcache
dc_resp_data  output  32  dcache read beat data
dc_done  output  1  one-cycle pulse: dcache transaction complete
mem_req_valid  output  1  memory command valid
mem_req_ready  input  1  memory accepts command
mem_req_addr  output  32  line-aligned memory address
mem_req_rw  output  1  1 = write burst
mem_wdata_valid  output  1  write beat valid
mem_wdata  output  32  write beat data
mem_wdata_ready  input  1  memory accepts write beat
mem_resp_valid  input  1  read beat returned
mem_resp_data  input  32  read beat data
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: state=IDLE, beat_cnt=0, last_grant=I, latched addr/rw/owner=0. All outputs are 0, including data outputs.
- States are IDLE, CMD, WDATA, RDATA, DONE.
- IDLE, request present:
  - Grant the sole valid requester. If both are valid, grant the one that is not last_grant; the first tie after reset goes to D.
  - Assert that requester's req_ready combinationally in the same cycle; no other ready is asserted.
  - Latch addr (with low OFF_BITS zeroed), rw (forced 0 for I), and owner. Update last_grant. Go to CMD.
- IDLE, no request: nothing happens. A mem_resp_valid arriving in IDLE is ignored.
- CMD:
  - mem_req_valid=1 with the latched addr/rw, held stable until mem_req_ready.
  - On handshake: go to WDATA if rw=1, else RDATA; beat_cnt=0.
- WDATA (owner is always D):
  - mem_wdata_valid=1; mem_wdata=dc_wdata (combinational pass-through).
  - dc_wdata_ready=mem_wdata_ready.
  - A beat is transferred when mem_wdata_ready=1; beat_cnt increments.
  - After beat BEATS-1 is transferred, go to DONE.
- RDATA:
  - On each mem_resp_valid, register data and assert {owner}_resp_valid with {owner}_resp_data the next cycle (1-cycle latency). The non-owner resp_valid stays 0.
  - beat_cnt increments per beat; back-to-back beats give back-to-back resp_valid.
  - After beat BEATS-1 is received, go to DONE. That last beat's resp_valid is asserted in the DONE cycle.
- DONE:
  - {owner}_done=1 for exactly one cycle; return to IDLE.
  - A new grant is possible in the IDLE cycle immediately following.
- Requests are not accepted while busy; requester valids may stay high and must hold addr/rw stable until ready.
- beat_cnt is log2(BEATS) bits wide and wraps to 0 at the end of each burst.
- Reset asserted mid-transaction:
  - Next edge aborts to IDLE with all outputs 0.
  - No done pulse and no further resp_valid; the partial burst is discarded.
  - Memory-side beats arriving after reset are ignored.
- mem_req_valid and mem_wdata_valid never drop before their ready handshake, except on reset.

Test Plan:
- Single icache read: ic_req_valid=1, addr=0x0000_1238, mem_req_ready=1, 4 resp beats 0xA0..0xA3 on consecutive cycles -> ic_req_ready pulses same cycle; mem_req_addr=0x0000_1230, rw=0; ic_resp_valid for 4 cycles with 0xA0..0xA3, each one cycle after its input beat; ic_done one cycle; dc outputs stay 0.
- Dcache write with backpressure: dc_req_rw=1, addr=0x400, mem_wdata_ready toggling 1,0,1,0,1,1 -> mem_req_rw=1; exactly 4 beats transferred only on ready cycles; dc_wdata_ready mirrors mem_wdata_ready; dc_done after 4th beat.
- Simultaneous requests twice in a row: both valid from reset -> D granted first, then I; next tie goes to D again; no ready while busy.
- Command stall: mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_req_addr stable for 5 cycles; no data beats issued.
- Reset mid-read after 2 of 4 beats -> busy=0 next cycle; no ic_done; late mem_resp_valid produces no ic_resp_valid/dc_resp_valid.
- Back-to-back: dcache read completes, icache valid waiting -> ic grant in the IDLE cycle right after the DONE cycle.
